// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/FA.sv
// Shared 1-bit full-adder cell, instantiated as-is by the serial datapath.
module FA (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic co
);

    assign sum = A ^ B ^ cin;
    assign co  = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell processes one bit per RUN cycle,
// LSB first, with the result shifted in from the MSB side.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (two's complement, cout=1 means no borrow).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the previous result
// RUN   | one bit per cycle through the full adder, WIDTH cycles
// DONE  | one-cycle done pulse, then back to IDLE
// 2'd3  | unreachable; recovers to IDLE
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             fa_sum;
    logic             fa_co;

    // Subtraction is a + ~b + 1, so it only changes what gets loaded.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    FA u_fa (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .cin (carry),
        .sum (fa_sum),
        .co  (fa_co)
    );

    // Sequencing FSM with registered busy/done and the serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: a vector table of single
// operations plus hand-written multi-cycle sequences (held start, operand
// change mid-run, reset mid-run).
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub_i;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int nchecks;
    int nerrs;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One operation from IDLE; chg>0 scrambles the inputs after that RUN edge.
    task automatic run_op(input string nm, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic vs, input logic [7:0] es,
                          input logic ec, input int chg);
        logic [7:0] held;
        @(negedge clk);
        a = va; b = vb; cin = vc; sub_i = vs; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_start"}, {30'd0, busy, done}, 32'h2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == chg) begin
                a = 8'h00; b = 8'h00; cin = ~vc; sub_i = ~vs;
            end
            if (k < 8) begin
                if ({busy, done} !== 2'b10)
                    chk({nm, $sformatf("_run%0d", k)}, {30'd0, busy, done}, 32'h2);
            end else begin
                chk({nm, "_done"}, {30'd0, busy, done}, 32'h1);
                chk({nm, "_sum"}, {24'd0, sum}, {24'd0, es});
                chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
            end
        end
        held = sum;
        @(negedge clk);
        chk({nm, "_after"}, {22'd0, busy, done, cout, held}, {22'd0, 2'b00, ec, es});
    endtask

    initial begin
        nchecks = 0;
        nerrs   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;

        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {21'd0, busy, done, cout, sum}, 32'h0);
        rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sub, vecs[i].s, vecs[i].co, 0);

        // Operands change after the 4th RUN edge; result must use captured values.
        run_op("midrun_change", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 4);

        // Start held for 20 cycles: done only at cycles 9 and 19, never with busy.
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; sub_i = 1'b0; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk($sformatf("held_done_c%0d", c), {31'd0, done},
                {31'd0, ((c == 9) || (c == 19)) ? 1'b1 : 1'b0});
            if (busy && done)
                chk($sformatf("held_overlap_c%0d", c), {30'd0, busy, done}, 32'h0);
        end
        start = 1'b0;
        chk("held_sum", {23'd0, cout, sum}, 32'h002);

        // Reset after the 5th RUN edge aborts with no done pulse.
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pre_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_state", {21'd0, busy, done, cout, sum}, 32'h0);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            chk("rst_no_done", seen, 0);
        end
        run_op("post_rst", 8'hC3, 8'h5A, 1'b1, 1'b0, 8'h1E, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range 2..32.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  is a synchronous, active-high reset.
REQ-004 Port start  input  1  is the operation request, sampled only in IDLE.
REQ-005 Port a  input  WIDTH  is the first operand, captured when start is accepted.
REQ-006 Port b  input  WIDTH  is the second operand, captured when start is accepted.
REQ-007 Port cin  input  1  is the carry-in, captured when start is accepted.
REQ-008 Port busy  output  1  is high while an operation is in RUN.
REQ-009 Port done  output  1  is a one-cycle pulse marking the result valid.
REQ-010 Port sum  output  WIDTH  is the result register.
REQ-011 Port cout  output  1  is the final carry-out.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per RUN cycle, through a single full-adder cell.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL capture a, b and cin into internal shift/carry registers, clear the bit counter to 0 and enter RUN.
REQ-015 RUN: each edge SHALL add the current LSBs with the carry register, shift the sum bit in from the MSB side, shift both operands right, update the carry and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL enter DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE on the next edge.
REQ-018 Latency: if start is sampled at edge E0, done SHALL be high in the cycle following edge E0+WIDTH.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; the two SHALL never be high together.
REQ-020 sum and cout SHALL hold their final values from DONE until the next accepted start.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; back-to-back operations need start high again in IDLE.
REQ-022 Changes on a, b and cin after capture SHALL NOT affect the result in progress.
REQ-023 Carry out of bit WIDTH-1 SHALL appear on cout; there is no wrap into bit 0.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, counter=0 and carry=0, taking priority over start.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN defined SHALL add the port sub  input  1, captured with the operands.
- sub=1: the result SHALL be a + ~b + 1, with cin ignored and cout=1 meaning no borrow.
- sub=0: behaviour is identical to the macro-undefined build.
REQ-027 Macro undefined SHALL give no sub port and addition only.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant; state 2'd3 SHALL recover to IDLE.
REQ-029 The per-bit add SHALL instantiate the team's existing 1-bit full-adder sub-module FA (ports A, B, cin, sum, co), used unchanged.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, all at WIDTH=8:
- a=0x5A, b=0x3C, cin=0, start pulse -> done after 9 edges, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0.
- start held high for 20 cycles from IDLE with a=0x01, b=0x01 -> done pulses at cycles 9 and 19; busy is never high together with done.
- Mid-RUN (cycle 4) drive a=0x00, b=0x00 -> result still reflects the captured operands.
- rst asserted in RUN cycle 5 -> IDLE next cycle, no done pulse, sum=0, cout=0; a following start completes normally.
- With SERIAL_ADDER_SUB_EN defined: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
